fifo_ctrl_param: RTL

FIFO_CTRL_PARAM -- requirements
Module: fifo_ctrl_param

---
 rtl/fifo_ctrl_param.sv | 115 +++++++++++
 1 files changed

// File: rtl/fifo_ctrl_param.sv
// fifo_ctrl_param: pointer/occupancy controller for a single-clock FIFO.
// It produces RAM write/read strobes and addresses, a registered occupancy
// count, registered level flags and sticky overflow/underflow indicators.
//
// Request semantics: wr and rd are per-cycle requests, not held handshakes.
// A request is accepted (wr_en / rd_en high) in the same cycle it is presented
// when the FIFO can honour it and no flush is pending. A rejected request is
// dropped and is not retried; the only trace it leaves is the sticky ovf/unf.
module fifo_ctrl_param #(
    parameter int ADDR_W = 5,
    parameter int AF_LVL = 28,
    parameter int AE_LVL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic              rd,
    input  logic              clr,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic [ADDR_W:0]   count,
    output logic              emp,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic              ovf,
    output logic              unf
);

    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AF_C    = AF_LVL[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_C    = AE_LVL[ADDR_W:0];

    // Reset release is pipelined through two flops; run only rises on the
    // second clock edge after rst_n goes high, so no state can change before then.
    logic [1:0] rst_sync;
    logic       run;

    logic [ADDR_W-1:0] wr_ptr_nxt;
    logic [ADDR_W-1:0] rd_ptr_nxt;
    logic [ADDR_W:0]   count_nxt;
    logic              ovf_nxt;
    logic              unf_nxt;

    // Reset synchroniser: assert asynchronously, release after two edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run = rst_sync[1];

    // Acceptance strobes: flush wins, and nothing is accepted while in reset.
    assign wr_en = run & wr & ~full & ~clr;
    assign rd_en = run & rd & ~emp  & ~clr;

    // Next-state computation for pointers, occupancy and sticky errors.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        ovf_nxt    = ovf | (wr & full);
        unf_nxt    = unf | (rd & emp);
        if (wr_en) begin
            wr_ptr_nxt = wr_ptr + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_nxt = rd_ptr + 1'b1;
        end
        case ({wr_en, rd_en})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
        if (clr) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
            ovf_nxt    = 1'b0;
            unf_nxt    = 1'b0;
        end
    end

    // State registers; flags are decoded from the next count so they line up
    // with the count they describe and come straight out of flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            emp          <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            ovf          <= 1'b0;
            unf          <= 1'b0;
        end else if (run) begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            emp          <= (count_nxt == '0);
            full         <= (count_nxt == DEPTH_C);
            almost_empty <= (count_nxt <= AE_C);
            almost_full  <= (count_nxt >= AF_C);
            ovf          <= ovf_nxt;
            unf          <= unf_nxt;
        end
    end

endmodule
